// File: rtl/perceptron_layer_sequencer.sv
// perceptron_layer_sequencer
//   Evaluates one layer of N_NEURONS perceptrons by time-multiplexing a single
//   signed multiply-accumulate over N_INPUTS inputs per neuron. Inputs and
//   coefficients come from external synchronous-read memories (1-cycle latency).
//   Each neuron sum passes through ReLU and leaves on a valid/ready port.
//
// Ports
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   start             : begin a layer pass (sampled only while not busy)
//   busy, done        : pass in progress / one-cycle pulse after final handshake
//   mem_rd            : read strobe for both memories
//   in_addr           : input index i
//   coef_addr         : coefficient index n*N_INPUTS + i
//   in_data/coef_data : read data, valid the cycle after mem_rd
//   res_valid/ready   : result handshake
//   res_data          : ReLU(neuron sum), res_index: neuron number
module perceptron_layer_sequencer #(
  parameter int N_INPUTS  = 50,
  parameter int N_NEURONS = 10,
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 40,
  localparam int AW = $clog2(N_INPUTS),
  localparam int CW = $clog2(N_INPUTS * N_NEURONS),
  localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_rd,
  output logic [AW-1:0]            in_addr,
  output logic [CW-1:0]            coef_addr,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] coef_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [ACC_W-1:0]  res_data,
  output logic [IW-1:0]            res_index
);

  localparam int PW = 2 * DATA_W;
  localparam logic [AW-1:0] LAST_I = AW'(N_INPUTS - 1);
  localparam logic [IW-1:0] LAST_N = IW'(N_NEURONS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_ACT,
    S_OUT,
    S_DONE
  } state_t;

  state_t                    state_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      mem_rd_q;
  logic                      rd_pending_q;
  logic                      res_valid_q;
  logic [AW-1:0]             in_addr_q;
  logic [CW-1:0]             coef_addr_q;
  logic [IW-1:0]             n_q;
  logic [IW-1:0]             res_index_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [ACC_W-1:0]   res_data_q;
  logic signed [PW-1:0]      in_ext;
  logic signed [PW-1:0]      coef_ext;
  logic signed [PW-1:0]      prod;

  // Operands widened first so the product keeps the full 2*DATA_W signed range.
  always_comb begin
    in_ext   = {{DATA_W{in_data[DATA_W-1]}}, in_data};
    coef_ext = {{DATA_W{coef_data[DATA_W-1]}}, coef_data};
    prod     = in_ext * coef_ext;
    acc_d    = acc_q;
    if (rd_pending_q) begin
      acc_d = acc_q + {{(ACC_W - PW){prod[PW-1]}}, prod};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_rd_q     <= 1'b0;
      rd_pending_q <= 1'b0;
      res_valid_q  <= 1'b0;
      in_addr_q    <= '0;
      coef_addr_q  <= '0;
      n_q          <= '0;
      res_index_q  <= '0;
      acc_q        <= '0;
      res_data_q   <= '0;
    end else begin
      rd_pending_q <= mem_rd_q;
      acc_q        <= acc_d;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (start) begin
            state_q     <= S_FETCH;
            busy_q      <= 1'b1;
            mem_rd_q    <= 1'b1;
            in_addr_q   <= '0;
            coef_addr_q <= '0;
            n_q         <= '0;
            acc_q       <= '0;
          end
        end
        S_FETCH: begin
          if (in_addr_q == LAST_I) begin
            mem_rd_q <= 1'b0;
            state_q  <= S_DRAIN;
          end else begin
            in_addr_q   <= in_addr_q + AW'(1);
            coef_addr_q <= coef_addr_q + CW'(1);
          end
        end
        S_DRAIN: begin
          state_q <= S_ACT;
        end
        S_ACT: begin
          res_data_q  <= (!acc_q[ACC_W-1] && (acc_q != '0)) ? acc_q : '0;
          res_index_q <= n_q;
          res_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            if (n_q != LAST_N) begin
              // Coefficients of consecutive neurons are contiguous, so the
              // next neuron's base is simply the last address plus one.
              n_q         <= n_q + IW'(1);
              in_addr_q   <= '0;
              coef_addr_q <= coef_addr_q + CW'(1);
              mem_rd_q    <= 1'b1;
              acc_q       <= '0;
              state_q     <= S_FETCH;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd    = mem_rd_q;
  assign in_addr   = in_addr_q;
  assign coef_addr = coef_addr_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_index = res_index_q;

endmodule

// File: tb/tb_perceptron_layer_sequencer.sv
// Testbench for perceptron_layer_sequencer: a small instance (4 inputs,
// 2 neurons) for directed, boundary, control and randomized passes, and a
// default-parameter instance for the full-scale no-overflow case.
module tb_perceptron_layer_sequencer;

  localparam int NI = 4;
  localparam int NN = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Small instance
  logic               a_start, a_busy, a_done, a_mem_rd, a_res_valid, a_res_ready;
  logic [1:0]         a_in_addr;
  logic [2:0]         a_coef_addr;
  logic signed [15:0] a_in_data = '0;
  logic signed [15:0] a_coef_data = '0;
  logic signed [39:0] a_res_data;
  logic [0:0]         a_res_index;

  // Default-parameter instance
  logic               b_start, b_busy, b_done, b_mem_rd, b_res_valid;
  logic               b_res_ready = 1'b1;
  logic [5:0]         b_in_addr;
  logic [8:0]         b_coef_addr;
  logic signed [15:0] b_in_data = '0;
  logic signed [15:0] b_coef_data = '0;
  logic signed [39:0] b_res_data;
  logic [3:0]         b_res_index;

  perceptron_layer_sequencer #(.N_INPUTS(NI), .N_NEURONS(NN), .DATA_W(16), .ACC_W(40)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .busy(a_busy), .done(a_done),
    .mem_rd(a_mem_rd), .in_addr(a_in_addr), .coef_addr(a_coef_addr),
    .in_data(a_in_data), .coef_data(a_coef_data), .res_valid(a_res_valid),
    .res_ready(a_res_ready), .res_data(a_res_data), .res_index(a_res_index)
  );

  perceptron_layer_sequencer dut_b (
    .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
    .mem_rd(b_mem_rd), .in_addr(b_in_addr), .coef_addr(b_coef_addr),
    .in_data(b_in_data), .coef_data(b_coef_data), .res_valid(b_res_valid),
    .res_ready(b_res_ready), .res_data(b_res_data), .res_index(b_res_index)
  );

  // Memory contents for the small instance
  int in_a[NI];
  int coef_a[NI*NN];

  // Synchronous-read memories, one cycle latency
  always @(posedge clk) begin
    if (a_mem_rd) begin
      a_in_data   <= 16'(in_a[a_in_addr]);
      a_coef_data <= 16'(coef_a[a_coef_addr]);
    end
    if (b_mem_rd) begin
      b_in_data   <= 16'sh8000;
      b_coef_data <= 16'sh8000;
    end
  end

  // Observation logs
  logic signed [39:0] a_res_q[$];
  int                 a_idx_q[$];
  logic [4:0]         a_addr_q[$];
  int                 a_flag_cnt = 0;
  logic signed [39:0] b_res_q[$];
  int                 b_idx_q[$];

  always @(posedge clk) begin
    if (a_mem_rd) a_addr_q.push_back({a_coef_addr, a_in_addr});
    if (a_res_valid && a_res_ready) begin
      a_res_q.push_back(a_res_data);
      a_idx_q.push_back(int'(a_res_index));
    end
    if (a_res_valid || a_done) a_flag_cnt++;
    if (b_res_valid && b_res_ready) begin
      b_res_q.push_back(b_res_data);
      b_idx_q.push_back(int'(b_res_index));
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: ReLU of the dot product of the input vector with neuron n's row
  function automatic longint model_a(int n);
    longint s = 0;
    for (int i = 0; i < NI; i++) s += longint'(in_a[i]) * longint'(coef_a[n*NI + i]);
    return (s > 0) ? s : 0;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic load_random();
    for (int i = 0; i < NI; i++) in_a[i] = rnd16();
    for (int j = 0; j < NI*NN; j++) coef_a[j] = rnd16();
  endtask

  task automatic load_directed();
    for (int i = 0; i < NI; i++) begin
      in_a[i]        = i + 1;
      coef_a[i]      = 1;
      coef_a[NI + i] = -1;
    end
  endtask

  function automatic logic [63:0] a_outs();
    return {a_busy, a_done, a_mem_rd, a_in_addr, a_coef_addr, a_res_valid, a_res_data, a_res_index};
  endfunction

  // One pass from start to done, optionally with random backpressure
  task automatic run_pass(input string tag, input bit rand_ready);
    int      base;
    bit      seen;
    longint  exp[NN];
    base = a_res_q.size();
    for (int n = 0; n < NN; n++) exp[n] = model_a(n);
    seen = 1'b0;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      a_res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      if (a_done) seen = 1'b1;
    end
    a_res_ready = 1'b1;
    check({tag, "_done"}, seen, 1);
    check({tag, "_count"}, a_res_q.size() - base, NN);
    for (int n = 0; n < NN; n++) begin
      check($sformatf("%s_data%0d", tag, n), (base + n < a_res_q.size()) ? a_res_q[base+n] : 'x, exp[n]);
      check($sformatf("%s_idx%0d", tag, n), (base + n < a_idx_q.size()) ? a_idx_q[base+n] : -1, n);
    end
    step();
  endtask

  // The 4-input / 2-neuron directed scenario with cycle-exact checks
  task automatic run_directed(input string tag, input bit poke, input bit chain);
    int rbase, abase, k2;
    bit seen;
    load_directed();
    rbase = a_res_q.size();
    abase = a_addr_q.size();
    a_res_ready = 1'b1;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    check({tag, "_e0"}, {a_mem_rd, a_busy, a_in_addr, a_coef_addr}, {1'b1, 1'b1, 2'd0, 3'd0});
    for (int k = 1; k <= 15; k++) begin
      if (poke && (k == 2 || k == 7 || k == 10)) a_start = 1'b1;
      step();
      a_start = 1'b0;
      case (k)
        3:  check({tag, "_e3"}, {a_mem_rd, a_in_addr, a_coef_addr}, {1'b1, 2'd3, 3'd3});
        4:  check({tag, "_e4_drain"}, a_mem_rd, 0);
        5:  check({tag, "_e5_novalid"}, a_res_valid, 0);
        6:  check({tag, "_e6_res0"}, {a_res_valid, a_busy, a_res_data, a_res_index}, {1'b1, 1'b1, 40'sd10, 1'b0});
        7:  check({tag, "_e7_fetch1"}, {a_res_valid, a_mem_rd, a_in_addr, a_coef_addr}, {1'b0, 1'b1, 2'd0, 3'd4});
        13: check({tag, "_e13_res1"}, {a_res_valid, a_busy, a_res_data, a_res_index}, {1'b1, 1'b1, 40'sd0, 1'b1});
        14: check({tag, "_e14_done"}, {a_done, a_busy, a_res_valid}, {1'b1, 1'b0, 1'b0});
        15: if (chain) check({tag, "_e15_restart"}, {a_done, a_busy, a_mem_rd, a_in_addr}, {1'b0, 1'b1, 1'b1, 2'd0});
            else       check({tag, "_e15_idle"}, {a_done, a_busy, a_mem_rd}, {1'b0, 1'b0, 1'b0});
        default: ;
      endcase
      if (k == 14) a_start = chain;
    end
    for (int j = 0; j < 2*NI; j++)
      check($sformatf("%s_addr%0d", tag, j), (abase + j < a_addr_q.size()) ? a_addr_q[abase+j] : 'x,
            {3'(j), 2'(j % NI)});
    if (!chain) check({tag, "_addr_count"}, a_addr_q.size() - abase, 2*NI);
    check({tag, "_res_count"}, a_res_q.size() - rbase, NN);
    if (chain) begin
      seen = 1'b0;
      k2 = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
        step();
        k2++;
        if (a_done) seen = 1'b1;
      end
      check({tag, "_chain_done_at"}, k2, 14);
      check({tag, "_chain_res_count"}, a_res_q.size() - rbase, 2*NN);
      check({tag, "_chain_res0"}, (rbase + 2 < a_res_q.size()) ? a_res_q[rbase+2] : 'x, 10);
      check({tag, "_chain_res1"}, (rbase + 3 < a_res_q.size()) ? a_res_q[rbase+3] : 'x, 0);
      step();
    end
  endtask

  initial begin
    int base, k, fbase;
    bit seen;
    longint exp0, exp1;

    reset = 1'b1;
    a_start = 1'b0;
    b_start = 1'b0;
    a_res_ready = 1'b1;
    for (int i = 0; i < NI; i++) in_a[i] = 0;
    for (int j = 0; j < NI*NN; j++) coef_a[j] = 0;
    step();
    step();
    check("reset_values", a_outs(), 0);
    reset = 1'b0;
    step();

    // Directed scenario
    run_directed("dir", 1'b0, 1'b0);

    // Asynchronous reset mid-pass during neuron 1 fetch
    load_directed();
    base = a_res_q.size();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int j = 0; j < 9; j++) step();
    check("abort_in_fetch1", {a_mem_rd, a_coef_addr}, {1'b1, 3'd6});
    #2 reset = 1'b1;
    #1 check("abort_async_zero", a_outs(), 0);
    step();
    reset = 1'b0;
    fbase = a_flag_cnt;
    for (int j = 0; j < 20; j++) step();
    check("abort_no_valid_done", a_flag_cnt - fbase, 0);
    check("abort_results", a_res_q.size() - base, 1);

    // Fresh start after abort reproduces the directed results, with start pokes while busy
    run_directed("post_abort_poke", 1'b1, 1'b0);

    // Start during DONE chains straight into a new pass
    run_directed("chain", 1'b0, 1'b1);

    // ReLU boundaries: sums 0 and -1, then +1
    for (int i = 0; i < NI; i++) in_a[i] = 1;
    coef_a = '{1, -1, 1, -1, -1, 0, 0, 0};
    base = a_res_q.size();
    run_pass("bnd_a", 1'b0);
    check("relu_sum_zero", (base < a_res_q.size()) ? a_res_q[base] : 'x, 0);
    check("relu_sum_m1", (base + 1 < a_res_q.size()) ? a_res_q[base+1] : 'x, 0);
    coef_a = '{1, 0, 0, 0, 2, -3, 0, 0};
    base = a_res_q.size();
    run_pass("bnd_b", 1'b0);
    check("relu_sum_p1", (base < a_res_q.size()) ? a_res_q[base] : 'x, 1);

    // Backpressure: hold res_ready low for 20 cycles in OUT
    load_random();
    exp0 = model_a(0);
    exp1 = model_a(1);
    base = a_res_q.size();
    a_res_ready = 1'b0;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    k = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      k++;
      if (a_res_valid) seen = 1'b1;
    end
    check("bp_valid_at", k, 6);
    for (int c = 0; c < 20; c++) begin
      step();
      check($sformatf("bp_hold%0d", c), {a_res_valid, a_mem_rd, a_in_addr, a_coef_addr, 40'(a_res_data), a_res_index},
            {1'b1, 1'b0, 2'd3, 3'd3, 40'(exp0), 1'b0});
    end
    a_res_ready = 1'b1;
    step();
    check("bp_release", {a_res_valid, a_mem_rd, a_in_addr, a_coef_addr}, {1'b0, 1'b1, 2'd0, 3'd4});
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (a_done) seen = 1'b1;
    end
    check("bp_done", seen, 1);
    check("bp_res1", (base + 1 < a_res_q.size()) ? a_res_q[base+1] : 'x, exp1);
    step();

    // Randomized passes with random backpressure
    for (int p = 0; p < 8; p++) begin
      load_random();
      run_pass($sformatf("rnd%0d", p), 1'b1);
    end

    // Default parameters, all operands -32768
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    k = 0;
    seen = 1'b0;
    for (int c = 0; c < 700 && !seen; c++) begin
      step();
      k++;
      if (b_done) seen = 1'b1;
    end
    check("full_done_at", k, 10 * 53);
    check("full_count", b_res_q.size(), 10);
    for (int n = 0; n < 10; n++) begin
      check($sformatf("full_data%0d", n), (n < b_res_q.size()) ? b_res_q[n] : 'x, 64'sd53687091200);
      check($sformatf("full_idx%0d", n), (n < b_idx_q.size()) ? b_idx_q[n] : -1, n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
